alu_addsub_chunked: RTL

//  Parametrised multi-cycle adder/subtractor, the word-level successor of the 1-bit opsel full adder.

---
 rtl/alu_addsub_chunked_if.sv | 29 ++
 rtl/alu_addsub_chunked.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_addsub_chunked_if.sv
// Operand/result bundle of the chunked add/subtract unit.
// The master side drives operands and consumes results; the slave side is the unit.
interface alu_addsub_chunked_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       opsel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, a, b, cin, opsel, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero, illegal
  );

  modport slave (
    input  in_valid, a, b, cin, opsel, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero, illegal
  );
endinterface

// File: rtl/alu_addsub_chunked.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle, with the
// inter-slice carry held in a register. Operands are captured at accept, so
// the upstream stage may change its outputs as soon as the handshake is done.
module alu_addsub_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                 clk,
  input logic                 rst,
  alu_addsub_chunked_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  if (WIDTH < 2) begin : g_bad_width
    $error("alu_addsub_chunked: WIDTH must be >= 2");
  end
  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("alu_addsub_chunked: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  // Decoded operation packed as {illegal, c0, b_op}. An illegal code decodes
  // to b_op=0, c0=0; the A operand is also zeroed at accept so the normal
  // datapath yields result=0, cout=0, ovf=0, zero=1.
  function automatic logic [WIDTH+1:0] decode_op(
    input logic [2:0]       opsel,
    input logic [WIDTH-1:0] b,
    input logic             cin
  );
    logic [WIDTH+1:0] dec;
    case (opsel)
      3'b000:  dec = {1'b0, 1'b0, b};                 // ADD
      3'b001:  dec = {1'b0, 1'b1, ~b};                // SUB
      3'b011:  dec = {1'b0, cin,  ~b};                // SUBB
      3'b100:  dec = {1'b0, 1'b0, {WIDTH{1'b0}}};     // PASS
      3'b101:  dec = {1'b0, 1'b0, {WIDTH{1'b1}}};     // DEC
      3'b110:  dec = {1'b0, cin,  b};                 // ADDC
      default: dec = {1'b1, 1'b0, {WIDTH{1'b0}}};     // 010, 111
    endcase
    return dec;
  endfunction

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bop_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;
  logic             illegal_r;

  logic [WIDTH+1:0] op_s;
  logic             accept_s;
  logic             last_s;
  int               base_s;
  logic [CHUNK-1:0] a_slice_s;
  logic [CHUNK-1:0] b_slice_s;
  logic [CHUNK:0]   slice_sum_s;
  logic [WIDTH-1:0] next_result_s;

  // Operand decode, handshake qualification and the per-slice adder.
  always_comb begin
    op_s          = decode_op(bus.opsel, bus.b, bus.cin);
    accept_s      = (state_r == IDLE) && !rst && bus.in_valid;
    last_s        = (idx_r == LAST_IDX);
    base_s        = int'(idx_r) * CHUNK;
    a_slice_s     = a_r[base_s +: CHUNK];
    b_slice_s     = bop_r[base_s +: CHUNK];
    slice_sum_s   = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {{CHUNK{1'b0}}, carry_r};
    next_result_s = result_r;
    next_result_s[base_s +: CHUNK] = slice_sum_s[CHUNK-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt_s   = state_r;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_r)
      IDLE: begin
        bus.in_ready = !rst;
        if (accept_s) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand capture, slice accumulation and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= {WIDTH{1'b0}};
      bop_r     <= {WIDTH{1'b0}};
      carry_r   <= 1'b0;
      idx_r     <= IDX_ZERO;
      result_r  <= {WIDTH{1'b0}};
      cout_r    <= 1'b0;
      ovf_r     <= 1'b0;
      zero_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r       <= op_s[WIDTH+1] ? {WIDTH{1'b0}} : bus.a;
            bop_r     <= op_s[WIDTH-1:0];
            carry_r   <= op_s[WIDTH];
            idx_r     <= IDX_ZERO;
            illegal_r <= op_s[WIDTH+1];
          end
        end
        CALC: begin
          result_r <= next_result_s;
          carry_r  <= slice_sum_s[CHUNK];
          if (last_s) begin
            idx_r  <= IDX_ZERO;
            cout_r <= slice_sum_s[CHUNK];
            ovf_r  <= (a_r[WIDTH-1] == bop_r[WIDTH-1]) &&
                      (next_result_s[WIDTH-1] != a_r[WIDTH-1]);
            zero_r <= (next_result_s == {WIDTH{1'b0}});
          end else begin
            idx_r  <= idx_r + IDX_ONE;
          end
        end
        default: begin
          // DONE holds everything stable until the result is taken.
        end
      endcase
    end
  end

  assign bus.result  = result_r;
  assign bus.cout    = cout_r;
  assign bus.ovf     = ovf_r;
  assign bus.zero    = zero_r;
  assign bus.illegal = illegal_r;

endmodule
